// File: rtl/delay_ctrl_pkg.sv
// Shared definitions for the echo-path delay-line sequencer.
package delay_ctrl_pkg;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SELECT = 2'd1;
    localparam state_t MIX    = 2'd2;
    localparam state_t SHIFT  = 2'd3;

    // Clamp limits for 16-bit signed audio samples
    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

    // fb_shift code that disables feedback
    localparam logic [2:0] FB_OFF = 3'd7;

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: sum formed in WIDTH+1 bits, clamped to the WIDTH range.
module sat_add #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);

    localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] sum;

    // Extended sum; top two bits disagreeing means overflow in that direction
    always_comb begin
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            y = sum[WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            y = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Echo-path delay-line sequencer: per codec sample, selects a tap as the wet signal,
// produces the dry/wet mix and the saturated feedback sample, then pulses shift_en once.
// Optional macro DELAY_RAMP_EN: tap index slews by at most one step per sample.
module delay_line_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_TAPS = 64,
    parameter int IDX_W    = 6
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      sample_valid,
    input  logic [WIDTH-1:0]          sample_in,
    input  logic [IDX_W-1:0]          delay_sel,
    input  logic [2:0]                fb_shift,
    input  logic                      bypass,
    input  logic [NUM_TAPS*WIDTH-1:0] taps,
    output logic [WIDTH-1:0]          line_in,
    output logic                      shift_en,
    output logic [WIDTH-1:0]          sample_out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
);

    state_t                  state;
    logic signed [WIDTH-1:0] dry_r;
    logic signed [WIDTH-1:0] wet_r;
    logic signed [WIDTH-1:0] line_r;
    logic signed [WIDTH-1:0] out_r;
    logic                    overrun_r;
    logic [IDX_W-1:0]        read_idx;
    logic signed [WIDTH-1:0] tap_sel;
    logic signed [WIDTH-1:0] wet_half;
    logic signed [WIDTH-1:0] wet_fb;
    logic signed [WIDTH-1:0] mix_sum;
    logic signed [WIDTH-1:0] fb_sum;
    logic signed [WIDTH-1:0] out_n;
    logic signed [WIDTH-1:0] line_n;

`ifdef DELAY_RAMP_EN
    logic [IDX_W-1:0] cur_idx;

    // Tap read uses the current index; the index then steps one toward delay_sel
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur_idx <= '0;
        end else if (state == SELECT) begin
            if (delay_sel > cur_idx) begin
                cur_idx <= cur_idx + 1'b1;
            end else if (delay_sel < cur_idx) begin
                cur_idx <= cur_idx - 1'b1;
            end
        end
    end

    assign read_idx = cur_idx;
`else
    // Without ramping the index simply follows delay_sel at tap-read time
    assign read_idx = delay_sel;
`endif

    assign tap_sel  = taps[read_idx*WIDTH +: WIDTH];
    assign wet_half = wet_r >>> 1;
    assign wet_fb   = wet_r >>> fb_shift;

    sat_add #(.WIDTH(WIDTH)) u_sat_out (
        .a (dry_r),
        .b (wet_half),
        .y (mix_sum)
    );

    sat_add #(.WIDTH(WIDTH)) u_sat_fb (
        .a (dry_r),
        .b (wet_fb),
        .y (fb_sum)
    );

    // Output and feedback selection; bypass keeps the line filling with clean signal
    always_comb begin
        out_n  = mix_sum;
        line_n = fb_sum;
        if (bypass) begin
            out_n  = dry_r;
            line_n = dry_r;
        end else if (fb_shift == FB_OFF) begin
            line_n = dry_r;
        end
    end

    // Sequencer FSM and datapath registers; samples arriving while busy are dropped
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            dry_r     <= '0;
            wet_r     <= '0;
            line_r    <= '0;
            out_r     <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (sample_valid && (state != IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        dry_r <= sample_in;
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    wet_r <= tap_sel;
                    state <= MIX;
                end
                MIX: begin
                    out_r  <= out_n;
                    line_r <= line_n;
                    state  <= SHIFT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign shift_en   = (state == SHIFT);
    assign out_valid  = (state == SHIFT);
    assign busy       = (state != IDLE);
    assign overrun    = overrun_r;
    assign line_in    = line_r;
    assign sample_out = out_r;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl; honours DELAY_RAMP_EN when defined.
module tb_delay_line_ctrl;

    localparam int WIDTH    = 16;
    localparam int NUM_TAPS = 64;
    localparam int IDX_W    = 6;

    logic                      clock = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      sample_valid = 1'b0;
    logic [WIDTH-1:0]          sample_in = '0;
    logic [IDX_W-1:0]          delay_sel = '0;
    logic [2:0]                fb_shift = 3'd7;
    logic                      bypass = 1'b0;
    logic [NUM_TAPS*WIDTH-1:0] taps;
    logic [WIDTH-1:0]          line_in;
    logic                      shift_en;
    logic [WIDTH-1:0]          sample_out;
    logic                      out_valid;
    logic                      busy;
    logic                      overrun;

    logic signed [WIDTH-1:0] tap_arr [NUM_TAPS];

    typedef struct {
        int          exp_c;
        logic [15:0] exp_out;
        logic [15:0] exp_line;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   m_idx = 0;

    delay_line_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .delay_sel    (delay_sel),
        .fb_shift     (fb_shift),
        .bypass       (bypass),
        .taps         (taps),
        .line_in      (line_in),
        .shift_en     (shift_en),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    always_comb begin
        taps = '0;
        for (int k = 0; k < NUM_TAPS; k++) taps[k*WIDTH +: WIDTH] = tap_arr[k];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: what the sample presented now should produce three cycles later
    task automatic push_expect(input logic [15:0] din);
        int   ridx;
        int   d;
        int   w;
        int   o;
        int   l;
        exp_t e;
`ifdef DELAY_RAMP_EN
        ridx = m_idx;
        if (int'(delay_sel) > m_idx) m_idx++;
        else if (int'(delay_sel) < m_idx) m_idx--;
`else
        ridx  = int'(delay_sel);
        m_idx = ridx;
`endif
        d = int'($signed(din));
        w = int'(tap_arr[ridx]);
        if (bypass) begin
            o = d;
            l = d;
        end else begin
            o = sat(d + (w >>> 1));
            l = (fb_shift == 3'd7) ? d : sat(d + (w >>> fb_shift));
        end
        e.exp_c    = cyc + 3;
        e.exp_out  = o[15:0];
        e.exp_line = l[15:0];
        q.push_back(e);
    endtask

    // Called just after a falling edge; occupies gap cycles
    task automatic issue(input logic [15:0] din, input int gap);
        push_expect(din);
        sample_in    = din;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        repeat (gap - 1) @(negedge clock);
    endtask

    task automatic fill_taps(input logic [15:0] v);
        for (int k = 0; k < NUM_TAPS; k++) tap_arr[k] = v;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a sample
    always @(negedge clock) begin
        if (out_valid || shift_en) begin
            check("strobe_pair", {out_valid, shift_en}, 2'b11);
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("latency", cyc, e.exp_c);
                check("sample_out", sample_out, e.exp_out);
                check("line_in", line_in, e.exp_line);
            end
        end
    end

    initial begin
        fill_taps(16'h0000);

        // Reset held with sample_valid toggling
        repeat (6) begin
            @(negedge clock);
            sample_valid = ~sample_valid;
        end
        check("reset_outputs", {shift_en, out_valid, busy, overrun, sample_out, line_in}, 0);
        @(negedge clock);
        check("reset_outputs_2", {shift_en, out_valid, busy, overrun, sample_out, line_in}, 0);
        sample_valid = 1'b0;
        reset_n      = 1'b1;
        m_idx        = 0;
        @(negedge clock);

        // Dry only, feedback off
        fb_shift  = 3'd7;
        delay_sel = 6'd0;
        issue(16'h1000, 5);

        // Basic mix from tap 5
        tap_arr[5] = 16'h2000;
        delay_sel  = 6'd5;
        fb_shift   = 3'd1;
        issue(16'h1000, 4);

        // Positive and negative saturation
        fill_taps(16'h7000);
        fb_shift = 3'd0;
        issue(16'h7000, 4);
        fill_taps(16'h9000);
        issue(16'h9000, 4);

        // Bypass
        bypass = 1'b1;
        for (int k = 0; k < NUM_TAPS; k++) tap_arr[k] = 16'($urandom);
        issue(16'h4321, 4);
        bypass = 1'b0;

`ifdef DELAY_RAMP_EN
        // Ramp from index 0 toward 3; tap k holds k+1, feedback exposes wet directly
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        m_idx   = 0;
        for (int k = 0; k < NUM_TAPS; k++) tap_arr[k] = 16'(k + 1);
        delay_sel = 6'd3;
        fb_shift  = 3'd0;
        repeat (6) issue(16'h0000, 4);
`endif

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < NUM_TAPS; k++) tap_arr[k] = 16'($urandom);
            delay_sel = 6'($urandom_range(0, NUM_TAPS - 1));
            fb_shift  = 3'($urandom_range(0, 7));
            bypass    = ($urandom_range(0, 7) == 0);
            issue(16'($urandom), int'($urandom_range(4, 6)));
        end
        bypass = 1'b0;

        // Overrun: second strobe two cycles later is dropped
        check("overrun_clear_before", overrun, 0);
        push_expect(16'h0123);
        sample_in    = 16'h0123;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        @(negedge clock);
        sample_in    = 16'h7777;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        @(negedge clock);
        check("overrun_set", overrun, 1);
        issue(16'h0456, 4);
        check("overrun_sticky", overrun, 1);

        // Reset during MIX aborts the sample
        sample_in    = 16'h2222;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_no_strobe", {out_valid, shift_en}, 0);
        check("abort_idle", busy, 0);
        check("abort_overrun_cleared", overrun, 0);
        reset_n = 1'b1;
        m_idx   = 0;
        @(negedge clock);
        issue(16'h0789, 4);

        // Drain
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        check("scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Sequencer for the 16-bit, 64-tap audio delay line (tap spacing 64 samples) in the guitar-pedal echo path. On each codec sample it selects one tap as the wet signal and computes the dry/wet output. It also computes the saturated feedback sample written into the line, then pulses the line's clock enable exactly once. It sits between the codec receive interface and the codec transmit interface.

## Interface
- WIDTH, 16, sample width (signed two's complement)
- NUM_TAPS, 64, taps provided by the delay line
- IDX_W, 6, tap-index width, log2(NUM_TAPS)

Ports:
- clock  in  1  system clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- sample_valid  in  1  one-cycle strobe: sample_in holds a new codec sample
- sample_in  in  WIDTH  dry input sample
- delay_sel  in  IDX_W  target tap index; tap k = delay of (k+1)*64 samples
- fb_shift  in  3  feedback attenuation: wet >>> fb_shift; 7 disables feedback
- bypass  in  1  output dry only; line is fed dry only
- taps  in  NUM_TAPS*WIDTH  delay-line taps; tap k = taps[k*WIDTH +: WIDTH]
- line_in  out  WIDTH  sample presented to delay-line shiftin
- shift_en  out  1  one-cycle clock enable to the delay line
- sample_out  out  WIDTH  processed output sample
- out_valid  out  1  one-cycle strobe: sample_out updated
- busy  out  1  high while not in IDLE
- overrun  out  1  sticky; set when sample_valid arrives while busy

## Operation
- FSM states: IDLE, SELECT, MIX, SHIFT.
- IDLE: on sample_valid, register sample_in into dry_r and go to SELECT. Otherwise stay in IDLE.
- SELECT: register wet_r = tap[cur_idx], then update cur_idx (see Configuration). Go to MIX.
- MIX:
  - sample_out_n = sat(dry_r + (wet_r >>> 1)).
  - line_in = sat(dry_r + (wet_r >>> fb_shift)), or dry_r if fb_shift==7.
  - Go to SHIFT.
- SHIFT: shift_en=1 and out_valid=1 for this single cycle; sample_out is registered. Go to IDLE.
- bypass=1, sampled in MIX: sample_out = dry_r and line_in = dry_r, so the line keeps filling with clean signal.
- sat(): the sum is computed in WIDTH+1 bits and clamps to +32767 / -32768.
- All shifts are arithmetic.
- line_in is held stable from MIX until the next MIX, so it is valid on the shift_en cycle.
- sample_valid while busy: the sample is dropped, overrun is set, and the state is unaffected. overrun clears only on reset.
- Exactly one shift_en per accepted sample; never two shift_en within 4 cycles.

## Timing
- Reset value of every output is 0. Internally, state=IDLE, cur_idx=0, dry_r=wet_r=0.
- Reset asserted mid-sequence: next cycle is IDLE, with no shift_en and no out_valid for the aborted sample.
- Latency: sample_valid at cycle N leads to shift_en and out_valid at cycle N+3.
- busy is high in cycles N+1..N+3.
- Minimum accepted sample spacing is 4 cycles.
- taps are sampled in SELECT, i.e. before that sample's shift_en.
- delay_sel and fb_shift are sampled in SELECT and MIX respectively; changes take effect on the next sample.

## Configuration
- DELAY_RAMP_EN defined:
  - cur_idx moves at most ±1 toward delay_sel per accepted sample, to avoid zipper clicks.
  - cur_idx equal to delay_sel: no change.
  - cur_idx never wraps from 63 to 0 or from 0 to 63.
- DELAY_RAMP_EN undefined: cur_idx = delay_sel immediately in SELECT, before the tap read.

## Structure
- Package delay_ctrl_pkg holds:
  - state enum (IDLE, SELECT, MIX, SHIFT);
  - SAMPLE_MAX / SAMPLE_MIN constants;
  - FB_OFF = 3'd7.
- One sub-module, sat_add (WIDTH-parameterised signed saturating adder), is instantiated twice: once for the output and once for feedback.

## Test plan
- Reset: hold reset_n=0 with sample_valid toggling -> all outputs 0, no shift_en. Release reset, then sample_valid with sample_in=0x1000, all taps 0, fb_shift=7 -> shift_en/out_valid at N+3, sample_out=0x1000, line_in=0x1000.
- Mix: tap5=0x2000, delay_sel=5, ramp disabled, fb_shift=1, sample_in=0x1000 -> sample_out=0x2000, line_in=0x2000.
- Saturation:
  - sample_in=0x7000, selected tap=0x7000, fb_shift=0 -> sample_out=0x7FFF, line_in=0x7FFF.
  - Negative case 0x9000/0x9000 -> 0x8000.
- Ramp (DELAY_RAMP_EN): cur_idx=0, delay_sel=3, each tap k = k+1 -> four samples read wet 1,2,3,4, then wet stays 4.
- Overrun: sample_valid at N and N+2 -> one shift_en only, at N+3; overrun=1 and stays set until reset.
- Reset mid-op: reset_n=0 at N+2 -> no shift_en at N+3, state IDLE, busy=0.
